// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the selects of a shared 8:1 mux.
// Optional hold timeout is enabled by defining MUX8_ARB_TIMEOUT_EN.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST_N    in   synchronous active-low reset
//   REQ      in   [7:0] per-source request
//   DONE     in   owner releases the grant (only looked at in BUSY)
//   GNT      out  [7:0] one-hot grant or zero, registered
//   S0,S1,S2 out  mux selects, S0 = owner index MSB, registered
//   VALID    out  high while GNT is nonzero, registered
//   TIMEOUT  out  one-cycle pulse on a forced release, registered
//
// Parameters (used only with MUX8_ARB_TIMEOUT_EN):
//   MAX_HOLD  max cycles an owner may keep the grant (1..255)
//   CNT_W     hold-counter width, 2**CNT_W > MAX_HOLD
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [7:0] GNT,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       VALID,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;

    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    logic       rel;
    logic       hold_exp;

    // Rotating priority search: first requester at or after ptr_q.
    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Owner lets go explicitly or by dropping its own request.
    assign rel = DONE || !REQ[sel_q];

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    assign hold_exp = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    // Parameters are meaningless without the timeout feature.
    logic [CNT_W-1:0] unused_hold;

    assign unused_hold = CNT_W'(MAX_HOLD);
    assign hold_exp    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
`ifdef MUX8_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = 8'd1 << pick;
                    sel_d   = pick;
                    valid_d = 1'b1;
                    ptr_d   = pick + 3'd1;
                    state_d = BUSY;
`ifdef MUX8_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // Selects keep the last owner; VALID qualifies them.
                if (rel || hold_exp) begin
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                    state_d = GAP;
`ifdef MUX8_ARB_TIMEOUT_EN
                    to_d    = !rel;
`endif
                end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign TIMEOUT = to_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT   = gnt_q;
    assign VALID = valid_q;
    assign S0    = sel_q[2];
    assign S1    = sel_q[1];
    assign S2    = sel_q[0];

endmodule
